zclock_gen: RTL and testbench

Generates the Z80 clock and the `zpos`/`zneg` phase strobes from the 28 MHz FPGA clock. It sits directly upstream of the Z80 signal decode/strobe stage, which latches bus signals on `zpos`. The block supports three turbo rates and a wait stall. Turbo changes take effect only at a rising Z80 edge, so the generated clock never produces a runt pulse.

---
 rtl/zclock_gen.sv | 116 +++++++++++
 tb/tb_zclock_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/zclock_gen.sv
// ---------------------------------------------------------------------------
// zclock_gen
//
// Purpose: derives the Z80 clock (zclk) and its one-cycle phase strobes
// (zpos ahead of a rising zclk edge, zneg ahead of a falling edge) from the
// 28 MHz FPGA clock. It offers three rates (3.5 / 7 / 14 MHz) and a wait
// stall that stretches the high phase.
//
// Ports:
//   clk        in  1  FPGA clock, all logic on posedge
//   rst_n      in  1  synchronous active-low reset
//   turbo      in  2  requested rate: 00 3.5 MHz, 01 7 MHz, 1x 14 MHz
//   wait_req   in  1  holds zclk high while asserted at the high terminal count
//   zclk       out 1  Z80 clock level (registered)
//   zpos       out 1  strobe: zclk rises at the end of this cycle
//   zneg       out 1  strobe: zclk falls at the end of this cycle
//   turbo_cur  out 2  rate currently applied (registered)
//   stall      out 1  a falling edge is being withheld by wait_req
//
// Handshake note: there is no valid/ready pair here. zpos/zneg/stall are
// single-cycle qualifiers valid in the cycle they are high; a consumer
// samples bus signals on the clk edge that ends a zpos cycle.
//
// The phase state machine is the pair (zclk, cnt). zclk is itself the
// state and is exported directly, so no separate debug port is needed.
// ---------------------------------------------------------------------------
module zclock_gen #(
    parameter logic [1:0] TURBO_RST = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] turbo,
    input  logic       wait_req,
    output logic       zclk,
    output logic       zpos,
    output logic       zneg,
    output logic [1:0] turbo_cur,
    output logic       stall
);

    // Registered state
    logic       r_zclk;
    logic [1:0] r_cnt;
    logic [1:0] r_turbo_cur;

    // Next-state values
    logic       w_zclk_nxt;
    logic [1:0] w_cnt_nxt;
    logic [1:0] w_turbo_nxt;

    // Decode
    logic [1:0] w_term_cnt;
    logic       w_term;
    logic       w_zpos;
    logic       w_zneg;
    logic       w_stall;

    // Terminal count is H-1 for the rate currently applied. The rate only
    // changes on a zpos edge, so a half-period never sees a mixed H.
    always_comb begin
        w_term_cnt = 2'd0;
        case (r_turbo_cur)
            2'b00:   w_term_cnt = 2'd3;
            2'b01:   w_term_cnt = 2'd1;
            default: w_term_cnt = 2'd0;
        endcase
    end

    assign w_term  = (r_cnt == w_term_cnt);
    assign w_zpos  = !r_zclk && w_term;
    assign w_zneg  =  r_zclk && w_term && !wait_req;
    assign w_stall =  r_zclk && w_term &&  wait_req;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zclk      <= 1'b0;
            r_cnt       <= 2'd0;
            r_turbo_cur <= TURBO_RST;
        end else begin
            r_zclk      <= w_zclk_nxt;
            r_cnt       <= w_cnt_nxt;
            r_turbo_cur <= w_turbo_nxt;
        end
    end

    // Next-state logic. wait_req only matters at the high terminal count,
    // where it freezes everything; elsewhere the counter simply advances.
    always_comb begin
        w_zclk_nxt  = r_zclk;
        w_cnt_nxt   = r_cnt;
        w_turbo_nxt = r_turbo_cur;
        if (w_zpos) begin
            w_zclk_nxt  = 1'b1;
            w_cnt_nxt   = 2'd0;
            w_turbo_nxt = turbo;
        end else if (w_zneg) begin
            w_zclk_nxt  = 1'b0;
            w_cnt_nxt   = 2'd0;
        end else if (w_stall) begin
            w_cnt_nxt   = r_cnt;
        end else begin
            w_cnt_nxt   = r_cnt + 2'd1;
        end
    end

    // Outputs
    always_comb begin
        zclk      = r_zclk;
        zpos      = w_zpos;
        zneg      = w_zneg;
        stall     = w_stall;
        turbo_cur = r_turbo_cur;
    end

endmodule

// File: tb/tb_zclock_gen.sv
// Bench for zclock_gen. Cycle n is the clk period that ends with the n-th
// edge after reset release; outputs are sampled 1 ns after the falling edge
// in the middle of that period.
module tb_zclock_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] turbo = 2'b00;
  logic       wait_req = 1'b0;
  logic       zclk, zpos, zneg, stall;
  logic [1:0] turbo_cur;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int nxt      = 0;

  // Reference model: level of zclk, cycles left in current half-period,
  // applied rate.
  logic       m_valid = 1'b0;
  logic       m_zclk;
  int         m_left;
  logic [1:0] m_tc;

  zclock_gen #(.TURBO_RST(2'b00)) dut (
    .clk(clk), .rst_n(rst_n), .turbo(turbo), .wait_req(wait_req),
    .zclk(zclk), .zpos(zpos), .zneg(zneg), .turbo_cur(turbo_cur),
    .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic int half_len(input logic [1:0] t);
    if (t == 2'b00) return 4;
    else if (t == 2'b01) return 2;
    else return 1;
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // One clk period: drive inputs, compare against the model, advance model.
  task automatic step(input logic rn, input logic [1:0] tb, input logic wr);
    logic last, e_pos, e_neg, e_stall;
    @(negedge clk);
    rst_n = rn; turbo = tb; wait_req = wr;
    cyc = nxt;
    #1;
    if (m_valid) begin
      last    = (m_left == 1);
      e_pos   = !m_zclk && last;
      e_neg   =  m_zclk && last && !wr;
      e_stall =  m_zclk && last &&  wr;
      chk("model_zclk", {1'b0, zclk}, {1'b0, m_zclk});
      chk("model_zpos", {1'b0, zpos}, {1'b0, e_pos});
      chk("model_zneg", {1'b0, zneg}, {1'b0, e_neg});
      chk("model_stall", {1'b0, stall}, {1'b0, e_stall});
      chk("model_turbo_cur", turbo_cur, m_tc);
      chk("strobe_exclusive", {1'b0, zpos & zneg}, 2'b00);
      if (rn) begin
        if (e_pos) begin
          m_zclk = 1'b1; m_tc = tb; m_left = half_len(tb);
        end else if (e_neg) begin
          m_zclk = 1'b0; m_left = half_len(m_tc);
        end else if (!e_stall) begin
          m_left--;
        end
      end
    end
    if (!rn) begin
      m_valid = 1'b1; m_zclk = 1'b0; m_tc = 2'b00; m_left = half_len(2'b00);
    end
    nxt = rn ? nxt + 1 : 0;
  endtask

  task automatic do_reset();
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    // Scenario 1: reset release at 3.5 MHz
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      step(1'b1, 2'b00, 1'b0);
      if (c == 0) begin
        chk("rst_zclk", {1'b0, zclk}, 2'd0);
        chk("rst_zpos", {1'b0, zpos}, 2'd0);
        chk("rst_tc", turbo_cur, 2'b00);
      end
      if (c == 3 || c == 11 || c == 19) chk("s1_zpos", {1'b0, zpos}, 2'd1);
      if (c == 7 || c == 15) chk("s1_zneg", {1'b0, zneg}, 2'd1);
      if (c == 4 || c == 7) chk("s1_zclk_hi", {1'b0, zclk}, 2'd1);
      if (c == 8 || c == 11) chk("s1_zclk_lo", {1'b0, zclk}, 2'd0);
    end

    // Scenario 2+3: 00 -> 10 in cycle 5, then 10 -> 00 in low cycle 17
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      step(1'b1, (c < 5) ? 2'b00 : (c < 17) ? 2'b10 : 2'b00, 1'b0);
      if (c == 10) chk("s2_tc_old", turbo_cur, 2'b00);
      if (c == 11) chk("s2_zpos11", {1'b0, zpos}, 2'd1);
      if (c == 12) begin
        chk("s2_zclk12", {1'b0, zclk}, 2'd1);
        chk("s2_zneg12", {1'b0, zneg}, 2'd1);
        chk("s2_tc12", turbo_cur, 2'b10);
      end
      if (c == 13) begin
        chk("s2_zclk13", {1'b0, zclk}, 2'd0);
        chk("s2_zpos13", {1'b0, zpos}, 2'd1);
      end
      if (c == 17) chk("s3_zpos17", {1'b0, zpos}, 2'd1);
      if (c == 18) chk("s3_tc18", turbo_cur, 2'b00);
      if (c == 20) chk("s3_zclk20", {1'b0, zclk}, 2'd1);
      if (c == 21) chk("s3_zneg21", {1'b0, zneg}, 2'd1);
      if (c == 22) chk("s3_zclk22", {1'b0, zclk}, 2'd0);
      if (c == 24) chk("s3_nozpos24", {1'b0, zpos}, 2'd0);
      if (c == 25) chk("s3_zpos25", {1'b0, zpos}, 2'd1);
    end

    // Scenario 4: wait_req in cycles 7..9
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      step(1'b1, 2'b00, (c >= 7 && c <= 9) ? 1'b1 : 1'b0);
      if (c >= 7 && c <= 9) begin
        chk("s4_stall", {1'b0, stall}, 2'd1);
        chk("s4_nozneg", {1'b0, zneg}, 2'd0);
      end
      if (c == 10) begin
        chk("s4_zneg10", {1'b0, zneg}, 2'd1);
        chk("s4_stall10", {1'b0, stall}, 2'd0);
      end
      if (c == 11) chk("s4_zclk11", {1'b0, zclk}, 2'd0);
      if (c == 14) chk("s4_zpos14", {1'b0, zpos}, 2'd1);
    end

    // Scenario 5: wait_req during low phase is ignored
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      step(1'b1, 2'b00, (c <= 2) ? 1'b1 : 1'b0);
      if (c == 3) chk("s5_zpos3", {1'b0, zpos}, 2'd1);
    end

    // Scenario 6: reset during a stall at 7 MHz, then restart timing
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      step(1'b1, 2'b01, (c >= 9) ? 1'b1 : 1'b0);
      if (c == 5) chk("s6_zneg5", {1'b0, zneg}, 2'd1);
      if (c == 7) chk("s6_zpos7", {1'b0, zpos}, 2'd1);
      if (c == 10) begin
        chk("s6_stall10", {1'b0, stall}, 2'd1);
        chk("s6_tc10", turbo_cur, 2'b01);
      end
    end
    step(1'b0, 2'b01, 1'b1);
    for (int c = 0; c <= 8; c++) begin
      step(1'b1, 2'b00, (c == 0) ? 1'b1 : 1'b0);
      if (c == 0) begin
        chk("s6_rst_zclk", {1'b0, zclk}, 2'd0);
        chk("s6_rst_tc", turbo_cur, 2'b00);
        chk("s6_rst_stall", {1'b0, stall}, 2'd0);
      end
      if (c == 3) chk("s6_zpos3", {1'b0, zpos}, 2'd1);
      if (c == 7) chk("s6_zneg7", {1'b0, zneg}, 2'd1);
    end

    // Scenario 7: turbo 11 runs as 14 MHz but reports 11
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      step(1'b1, 2'b11, 1'b0);
      if (c == 4) begin
        chk("s7_tc11", turbo_cur, 2'b11);
        chk("s7_zneg4", {1'b0, zneg}, 2'd1);
      end
      if (c == 5) chk("s7_zpos5", {1'b0, zpos}, 2'd1);
      if (c == 6) chk("s7_zneg6", {1'b0, zneg}, 2'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
